sample_scheduler: RTL and testbench

SAMPLE_SCHEDULER -- requirements
Module: sample_scheduler

---
 rtl/sched_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 36 +++
 rtl/sample_scheduler.sv | 159 +++++++++++++++
 tb/tb_sample_scheduler.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/sched_pkg.sv
// Shared defaults and state encoding for the periodic sample scheduler.
package sched_pkg;

    localparam int N_TASK_DEF        = 4;
    localparam int TIMEOUT_TICKS_DEF = 20;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2
    } sched_state_e;

    // Width of a task index; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: scans the pending vector starting one past the
// previously granted index and wrapping around.
module rr_arbiter
    import sched_pkg::*;
#(
    parameter  int N   = N_TASK_DEF,
    localparam int IDW = idx_width(N)
) (
    input  logic [N-1:0]   i_pending,
    input  logic [IDW-1:0] i_last,
    output logic [N-1:0]   o_grant,
    output logic [IDW-1:0] o_index,
    output logic           o_valid
);

    logic [IDW-1:0] w_cand;

    // First pending task found after i_last (mod N) wins.
    always_comb begin
        o_grant = '0;
        o_index = '0;
        o_valid = 1'b0;
        w_cand  = '0;
        for (int k = 1; k <= N; k++) begin
            w_cand = IDW'((int'(i_last) + k) % N);
            if (!o_valid && i_pending[w_cand]) begin
                o_valid         = 1'b1;
                o_index         = w_cand;
                o_grant[w_cand] = 1'b1;
            end else begin
                o_valid = o_valid;
            end
        end
    end

endmodule

// File: rtl/sample_scheduler.sv
// Periodic sampling scheduler: per-task period counters raise pending
// requests, one task at a time is started and supervised for DONE/timeout.
module sample_scheduler
    import sched_pkg::*;
#(
    parameter  int N_TASK        = N_TASK_DEF,
    parameter  int TIMEOUT_TICKS = TIMEOUT_TICKS_DEF,
    localparam int IDW           = idx_width(N_TASK)
) (
    input  logic                  CLK_10HZ,
    input  logic                  RESET,
    input  logic [23:0]           i_timestamp,
    input  logic [N_TASK-1:0]     i_enable,
    input  logic [8*N_TASK-1:0]   i_period,
    input  logic [N_TASK-1:0]     i_done,
    input  logic                  i_clr_ovr,
    output logic [N_TASK-1:0]     o_start,
    output logic                  o_busy,
    output logic [IDW-1:0]        o_grant_id,
    output logic [23:0]           o_grant_ts,
    output logic [N_TASK-1:0]     o_overrun,
    output logic [N_TASK-1:0]     o_timeout_flag
);

    localparam int TCW = $clog2(TIMEOUT_TICKS + 1);
    // The START cycle and the WAIT entry edge already account for two ticks,
    // so the flag fires on the edge that is TIMEOUT_TICKS after the START edge.
    localparam logic [TCW-1:0] TC_LAST = TCW'(TIMEOUT_TICKS - 2);

    logic [N_TASK-1:0][7:0] r_cnt;
    logic [N_TASK-1:0]      r_pending;
    sched_state_e           r_state;
    logic [TCW-1:0]         r_tcnt;
    logic [N_TASK-1:0]      r_start;
    logic                   r_busy;
    logic [IDW-1:0]         r_grant_id;
    logic [23:0]            r_grant_ts;
    logic [N_TASK-1:0]      r_overrun;
    logic [N_TASK-1:0]      r_timeout;

    logic [N_TASK-1:0]      w_active;
    logic [N_TASK-1:0]      w_expire;
    logic [N_TASK-1:0]      w_arb_grant;
    logic [IDW-1:0]         w_arb_idx;
    logic                   w_arb_valid;
    sched_state_e           w_state_nxt;
    logic [TCW-1:0]         w_tcnt_nxt;
    logic                   w_take;
    logic                   w_to_hit;
    logic [N_TASK-1:0]      w_clear;
    logic [N_TASK-1:0]      w_to_set;

    rr_arbiter #(.N(N_TASK)) u_arb (
        .i_pending (r_pending),
        .i_last    (r_grant_id),
        .o_grant   (w_arb_grant),
        .o_index   (w_arb_idx),
        .o_valid   (w_arb_valid)
    );

    // A task is live when enabled with a non-zero period; it expires when its counter is 1.
    always_comb begin
        w_active = '0;
        w_expire = '0;
        for (int i = 0; i < N_TASK; i++) begin
            w_active[i] = i_enable[i] && (i_period[8*i +: 8] != 8'd0);
            w_expire[i] = w_active[i] && (r_cnt[i] == 8'd1);
        end
    end

    // Per-task period down-counters; idle tasks park at 1 so they expire on the first live tick.
    always_ff @(posedge CLK_10HZ or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < N_TASK; i++) r_cnt[i] <= 8'd1;
        end else begin
            for (int i = 0; i < N_TASK; i++) begin
                if (!w_active[i])      r_cnt[i] <= 8'd1;
                else if (w_expire[i])  r_cnt[i] <= i_period[8*i +: 8];
                else                   r_cnt[i] <= r_cnt[i] - 8'd1;
            end
        end
    end

    // Next-state and grant/timeout decisions for the IDLE/START/WAIT sequencer.
    always_comb begin
        w_state_nxt = r_state;
        w_tcnt_nxt  = r_tcnt;
        w_take      = 1'b0;
        w_to_hit    = 1'b0;
        w_to_set    = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_arb_valid) begin
                    w_take      = 1'b1;
                    w_state_nxt = ST_START;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_START: begin
                w_tcnt_nxt  = '0;
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (i_done[r_grant_id]) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_tcnt == TC_LAST) begin
                    w_to_hit             = 1'b1;
                    w_to_set[r_grant_id] = 1'b1;
                    w_state_nxt          = ST_IDLE;
                end else begin
                    w_tcnt_nxt = r_tcnt + TCW'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        w_clear = w_take ? w_arb_grant : '0;
    end

    // Sequencer state, pending set/clear (set wins), grant capture and sticky error flags.
    always_ff @(posedge CLK_10HZ or negedge RESET) begin
        if (!RESET) begin
            r_state    <= ST_IDLE;
            r_tcnt     <= '0;
            r_pending  <= '0;
            r_start    <= '0;
            r_busy     <= 1'b0;
            r_grant_id <= IDW'(N_TASK - 1);
            r_grant_ts <= 24'd0;
            r_overrun  <= '0;
            r_timeout  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_tcnt    <= w_tcnt_nxt;
            r_pending <= (r_pending & ~w_clear & w_active) | w_expire;
            r_start   <= w_take ? w_arb_grant : '0;
            r_busy    <= (w_state_nxt != ST_IDLE);
            if (w_take) begin
                r_grant_id <= w_arb_idx;
                r_grant_ts <= i_timestamp;
            end else begin
                r_grant_id <= r_grant_id;
                r_grant_ts <= r_grant_ts;
            end
            r_overrun <= (r_overrun & ~{N_TASK{i_clr_ovr}}) | (w_expire & r_pending & ~w_clear);
            r_timeout <= (r_timeout & ~{N_TASK{i_clr_ovr}}) | (w_to_hit ? w_to_set : '0);
        end
    end

    assign o_start        = r_start;
    assign o_busy         = r_busy;
    assign o_grant_id     = r_grant_id;
    assign o_grant_ts     = r_grant_ts;
    assign o_overrun      = r_overrun;
    assign o_timeout_flag = r_timeout;

endmodule

// File: tb/tb_sample_scheduler.sv
// Directed bench for sample_scheduler: reset, periodic single task,
// round-robin contention, overrun, timeout, zero period, mid-task reset.
module tb_sample_scheduler;
    import sched_pkg::*;

    logic        CLK_10HZ = 1'b0;
    logic        RESET;
    logic [23:0] ts;
    logic [3:0]  en;
    logic [31:0] per;
    logic [3:0]  done;
    logic        clr;
    logic [3:0]  start;
    logic        busy;
    logic [1:0]  gid;
    logic [23:0] gts;
    logic [3:0]  ovr;
    logic [3:0]  tof;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          done_delay;
    int          done_cnt;
    logic [1:0]  done_id;

    always #5 CLK_10HZ = ~CLK_10HZ;

    sample_scheduler dut (
        .CLK_10HZ       (CLK_10HZ),
        .RESET          (RESET),
        .i_timestamp    (ts),
        .i_enable       (en),
        .i_period       (per),
        .i_done         (done),
        .i_clr_ovr      (clr),
        .o_start        (start),
        .o_busy         (busy),
        .o_grant_id     (gid),
        .o_grant_ts     (gts),
        .o_overrun      (ovr),
        .o_timeout_flag (tof)
    );

    // One tick; optionally answers each START with DONE done_delay ticks later.
    task automatic step();
        @(posedge CLK_10HZ);
        #1;
        ts = ts + 24'd1;
        if (done_delay > 0) begin
            done = 4'b0000;
            if (done_cnt > 0) begin
                done_cnt = done_cnt - 1;
                if (done_cnt == 0) done[done_id] = 1'b1;
            end
            if (start != 4'b0000) begin
                for (int i = 0; i < 4; i++) if (start[i]) done_id = 2'(i);
                done_cnt = done_delay;
            end
        end
    endtask

    task automatic do_reset(input logic [3:0] e, input logic [31:0] p, input int dd);
        RESET = 1'b0; en = 4'b0; per = 32'd0; done = 4'b0; clr = 1'b0;
        done_delay = dd; done_cnt = 0; done_id = 2'd0;
        repeat (2) @(posedge CLK_10HZ);
        #1;
        en = e; per = p;
        RESET = 1'b1;
    endtask

    task automatic test_reset();
        RESET = 1'b0; en = 4'b0; per = 32'd0; done = 4'b0; clr = 1'b0; ts = 24'd0;
        done_delay = -1; done_cnt = 0; done_id = 2'd0;
        repeat (2) @(posedge CLK_10HZ);
        #1;
        n_checks++; if (start !== 4'b0000) begin n_fail++; $display("FAIL reset_start: got %b expected 0000", start); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (gid !== 2'd3) begin n_fail++; $display("FAIL reset_grant_id: got %0d expected 3", gid); end
        n_checks++; if (gts !== 24'd0) begin n_fail++; $display("FAIL reset_grant_ts: got %0d expected 0", gts); end
        n_checks++; if (ovr !== 4'b0000) begin n_fail++; $display("FAIL reset_overrun: got %b expected 0000", ovr); end
        n_checks++; if (tof !== 4'b0000) begin n_fail++; $display("FAIL reset_timeout: got %b expected 0000", tof); end
    endtask

    task automatic test_single_task();
        int          cnt;
        int          st_edge [4];
        logic [23:0] st_ts [4];
        logic [23:0] t0;
        do_reset(4'b0001, {24'd0, 8'd5}, 2);
        t0 = ts;
        cnt = 0;
        for (int k = 1; k <= 14; k++) begin
            step();
            if (start != 4'b0000) begin
                n_checks++; if (start !== 4'b0001) begin n_fail++; $display("FAIL single_start_vec: got %b expected 0001", start); end
                if (cnt < 4) begin st_edge[cnt] = k; st_ts[cnt] = gts; end
                cnt++;
            end
            if (k == 4) begin
                n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_wait: got %b expected 1", busy); end
            end
            if (k == 5) begin
                n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_idle: got %b expected 0", busy); end
            end
        end
        n_checks++; if (cnt !== 3) begin n_fail++; $display("FAIL single_start_count: got %0d expected 3", cnt); end
        if (cnt >= 3) begin
            n_checks++; if (st_edge[0] !== 2) begin n_fail++; $display("FAIL single_first_edge: got %0d expected 2", st_edge[0]); end
            n_checks++; if (st_edge[1] - st_edge[0] !== 5) begin n_fail++; $display("FAIL single_period1: got %0d expected 5", st_edge[1] - st_edge[0]); end
            n_checks++; if (st_edge[2] - st_edge[1] !== 5) begin n_fail++; $display("FAIL single_period2: got %0d expected 5", st_edge[2] - st_edge[1]); end
            n_checks++; if (st_ts[0] !== t0 + 24'd1) begin n_fail++; $display("FAIL single_ts0: got %0d expected %0d", st_ts[0], t0 + 24'd1); end
            n_checks++; if (st_ts[1] - st_ts[0] !== 24'd5) begin n_fail++; $display("FAIL single_ts_delta1: got %0d expected 5", st_ts[1] - st_ts[0]); end
            n_checks++; if (st_ts[2] - st_ts[1] !== 24'd5) begin n_fail++; $display("FAIL single_ts_delta2: got %0d expected 5", st_ts[2] - st_ts[1]); end
        end
    endtask

    task automatic test_contention();
        int cnt;
        int exp_edge [5] = '{2, 5, 8, 11, 14};
        int exp_id   [5] = '{0, 1, 2, 3, 0};
        do_reset(4'b1111, {8'd10, 8'd10, 8'd10, 8'd10}, 1);
        cnt = 0;
        for (int k = 1; k <= 15; k++) begin
            step();
            if (start != 4'b0000) begin
                if (cnt < 5) begin
                    n_checks++; if (k !== exp_edge[cnt]) begin n_fail++; $display("FAIL rr_edge%0d: got %0d expected %0d", cnt, k, exp_edge[cnt]); end
                    n_checks++; if (gid !== 2'(exp_id[cnt])) begin n_fail++; $display("FAIL rr_id%0d: got %0d expected %0d", cnt, gid, exp_id[cnt]); end
                    n_checks++; if (start !== (4'b0001 << exp_id[cnt])) begin n_fail++; $display("FAIL rr_onehot%0d: got %b", cnt, start); end
                end
                cnt++;
            end
        end
        n_checks++; if (cnt !== 5) begin n_fail++; $display("FAIL rr_count: got %0d expected 5", cnt); end
        n_checks++; if (ovr !== 4'b0000) begin n_fail++; $display("FAIL rr_no_overrun: got %b expected 0000", ovr); end
    endtask

    task automatic test_overrun();
        do_reset(4'b0001, {24'd0, 8'd2}, 5);
        repeat (4) step();
        n_checks++; if (ovr !== 4'b0000) begin n_fail++; $display("FAIL ovr_before: got %b expected 0000", ovr); end
        step();
        n_checks++; if (ovr !== 4'b0001) begin n_fail++; $display("FAIL ovr_set: got %b expected 0001", ovr); end
        step();
        en = 4'b0000;
        step();
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ovr_no_abort: got %b expected 1", busy); end
        step();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ovr_done_idle: got %b expected 0", busy); end
        step();
        n_checks++; if (start !== 4'b0000) begin n_fail++; $display("FAIL ovr_no_restart: got %b expected 0000", start); end
        n_checks++; if (ovr !== 4'b0001) begin n_fail++; $display("FAIL ovr_sticky: got %b expected 0001", ovr); end
        clr = 1'b1;
        step();
        clr = 1'b0;
        n_checks++; if (ovr !== 4'b0000) begin n_fail++; $display("FAIL ovr_clear: got %b expected 0000", ovr); end
    endtask

    task automatic test_timeout();
        do_reset(4'b0011, {16'd0, 8'd50, 8'd50}, -1);
        step(); step();
        n_checks++; if (start !== 4'b0001) begin n_fail++; $display("FAIL to_first_start: got %b expected 0001", start); end
        repeat (19) step();
        n_checks++; if (tof !== 4'b0000) begin n_fail++; $display("FAIL to_early: got %b expected 0000", tof); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL to_busy_early: got %b expected 1", busy); end
        step();
        n_checks++; if (tof !== 4'b0001) begin n_fail++; $display("FAIL to_flag: got %b expected 0001", tof); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL to_idle: got %b expected 0", busy); end
        step();
        n_checks++; if (start !== 4'b0010) begin n_fail++; $display("FAIL to_next_start: got %b expected 0010", start); end
        n_checks++; if (gid !== 2'd1) begin n_fail++; $display("FAIL to_next_id: got %0d expected 1", gid); end
    endtask

    task automatic test_period_zero();
        int n0;
        int n1;
        do_reset(4'b0011, {16'd0, 8'd0, 8'd3}, 1);
        n0 = 0; n1 = 0;
        for (int k = 1; k <= 15; k++) begin
            step();
            if (start[0]) n0++;
            if (start[1]) n1++;
        end
        n_checks++; if (n1 !== 0) begin n_fail++; $display("FAIL pz_task1_starts: got %0d expected 0", n1); end
        n_checks++; if (n0 !== 5) begin n_fail++; $display("FAIL pz_task0_starts: got %0d expected 5", n0); end
        n_checks++; if (ovr !== 4'b0000) begin n_fail++; $display("FAIL pz_overrun: got %b expected 0000", ovr); end
    endtask

    task automatic test_reset_mid_task();
        do_reset(4'b0001, {24'd0, 8'd5}, -1);
        repeat (4) step();
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mr_busy_before: got %b expected 1", busy); end
        #2;
        RESET = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mr_busy_async: got %b expected 0", busy); end
        n_checks++; if (gid !== 2'd3) begin n_fail++; $display("FAIL mr_grant_id: got %0d expected 3", gid); end
        done = 4'b0001;
        @(posedge CLK_10HZ);
        #1;
        RESET = 1'b1;
        step();
        n_checks++; if (start !== 4'b0000) begin n_fail++; $display("FAIL mr_first_edge: got %b expected 0000", start); end
        step();
        done = 4'b0000;
        n_checks++; if (start !== 4'b0001) begin n_fail++; $display("FAIL mr_restart: got %b expected 0001", start); end
    endtask

    initial begin
        test_reset();
        test_single_task();
        test_contention();
        test_overrun();
        test_timeout();
        test_period_zero();
        test_reset_mid_task();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
